digit_serial_add_sub: RTL and testbench
=======================================

// Module: digit_serial_add_sub
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
//   Each digit uses a DIGIT-wide ripple-carry full-adder chain; carry is registered between digits.
//   Trades latency for area against a flat WIDTH-bit ripple adder.
//   Adds subtract mode, signed-overflow flag and valid/ready handshakes on both sides.
//   Used by datapath blocks that tolerate WIDTH/DIGIT-cycle arithmetic.
// PARAMETERS
//   WIDTH  16  operand/result width; >=2
//   DIGIT  4   bits processed per cycle; 1..WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise)
//   STEPS = WIDTH/DIGIT (localparam)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      add: carry-in; sub: borrow-in
//   sub        in   1      0: a+b+c_in; 1: a-b-c_in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result mod 2^WIDTH
//   c_out      out  1      raw carry out of MSB; in sub mode 1 = no borrow
//   overflow   out  1      two's-complement overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//   Reset (async assert, rst_n low): state=IDLE, step=0, in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0.
//   Reset mid-operation: in-flight operation discarded; nothing emitted.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge, register:
//     - opA = a
//     - opB = sub ? ~b : b
//     - carry = sub ? ~c_in : c_in
//     - step = 0
//     Then go to RUN.
//   RUN: in_ready=0; a/b/c_in/sub/in_valid ignored. Each edge:
//     - Digit `step` = opA[digit] + opB[digit] + carry.
//     - Write that digit into the sum register; update carry.
//     - step++.
//     - On the edge with step==STEPS-1: latch c_out=carry_out, overflow=carry_into_MSB ^ carry_out; go to DONE.
//   DONE: out_valid=1. sum/c_out/overflow stay stable until the out_valid&&out_ready edge, then go to IDLE.
//     While waiting (out_ready=0): in_ready=0.
//   Latency: accept at edge E0 -> out_valid high after edge E_STEPS (STEPS cycles).
//     Minimum issue interval STEPS+2 cycles (no overlap of accept and emit).
//   sum bits not yet written during RUN hold their previous values. Only values visible while out_valid=1 are defined.
//   DIGIT==WIDTH: STEPS=1, single RUN cycle.
//   Wrap-around: results are modulo 2^WIDTH; no saturation.
// TESTING (WIDTH=16, DIGIT=4 unless stated)
//   1. a=0x1234, b=0x0FED, c_in=0, add -> sum=0x2221, c_out=0, ovf=0; out_valid exactly 4 cycles after accept.
//   2. a=0xFFFF, b=0x0001, c_in=0, add -> sum=0x0000, c_out=1, ovf=0.
//      a=0x7FFF, b=0x0001, add -> sum=0x8000, c_out=0, ovf=1.
//   3. a=0x0005, b=0x0007, c_in=0, sub -> sum=0xFFFE, c_out=0, ovf=0.
//      a=0x8000, b=0x0001, sub -> sum=0x7FFF, c_out=1, ovf=1.
//      a=0x0005, b=0x0002, c_in=1, sub -> sum=0x0002, c_out=1.
//   4. Hold out_ready=0 for 5 cycles in DONE; drive in_valid with new data.
//      -> out_valid stays 1, outputs stable, in_ready=0, new data ignored; accepted only after drain.
//   5. rst_n low after 2 RUN cycles -> out_valid=0, in_ready=1 immediately; next op (0x0001+0x0001) -> 0x0002.
//   6. WIDTH=4 with DIGIT in {1,2,4}: exhaustive a, b, c_in, sub (1024 ops) with random out_ready.
//      -> sum, c_out, ovf match a behavioural model; latency = STEPS.

Source files
------------

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB digit first,
// with the carry held in a register between digits and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one digit per clock, STEPS clocks in total
// DONE  | out_valid high, result held until out_ready
module digit_serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("digit_serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]                  state;
  logic [SW-1:0]               step;
  logic [STEPS-1:0][DIGIT-1:0] op_a;
  logic [STEPS-1:0][DIGIT-1:0] op_b;
  logic [STEPS-1:0][DIGIT-1:0] sum_r;
  logic                        carry;
  logic                        c_out_r;
  logic                        overflow_r;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic [DIGIT:0]   chain;
  logic             last_step;

  assign dig_a     = op_a[step];
  assign dig_b     = op_b[step];
  assign last_step = (step == SW'(STEPS - 1));

  // One ripple-carry chain, DIGIT bits long, shared by every digit position.
  always_comb begin
    chain    = '0;
    dig_s    = '0;
    chain[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dig_s[i]     = dig_a[i] ^ dig_b[i] ^ chain[i];
      chain[i + 1] = (dig_a[i] & dig_b[i]) | (chain[i] & (dig_a[i] ^ dig_b[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      sum_r      <= '0;
      carry      <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~borrow, so only the operand and carry-in are inverted.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= c_in ^ sub;
            step  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[step] <= dig_s;
          carry       <= chain[DIGIT];
          if (last_step) begin
            c_out_r    <= chain[DIGIT];
            overflow_r <= chain[DIGIT] ^ chain[DIGIT-1];
            step       <= '0;
            state      <= DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: directed and random 16-bit/4-digit ops plus exhaustive
// 4-bit ops for DIGIT = 1, 2, 4, all compared against a plain-arithmetic model.
module tb_digit_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  logic       sm_in_valid [3];
  logic       sm_in_ready [3];
  logic [3:0] sm_a        [3];
  logic [3:0] sm_b        [3];
  logic       sm_c_in     [3];
  logic       sm_sub      [3];
  logic       sm_out_valid[3];
  logic       sm_out_ready[3];
  logic [3:0] sm_sum      [3];
  logic       sm_c_out    [3];
  logic       sm_overflow [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  for (genvar g = 0; g < 3; g++) begin : g_small
    digit_serial_add_sub #(.WIDTH(4), .DIGIT(1 << g)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(sm_in_valid[g]), .in_ready(sm_in_ready[g]),
      .a(sm_a[g]), .b(sm_b[g]), .c_in(sm_c_in[g]), .sub(sm_sub[g]),
      .out_valid(sm_out_valid[g]), .out_ready(sm_out_ready[g]),
      .sum(sm_sum[g]), .c_out(sm_c_out[g]), .overflow(sm_overflow[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Packed result: sum | c_out << w | overflow << (w+1), from integer arithmetic.
  function automatic logic [31:0] ref_model(input int w, input int ua, input int ub,
                                            input bit cin, input bit sb);
    longint m  = longint'(1) << w;
    longint h  = m / 2;
    longint sa = (ua >= h) ? ua - m : longint'(ua);
    longint sv = (ub >= h) ? ub - m : longint'(ub);
    longint r;
    longint sr;
    bit     co;
    bit     ov;
    if (sb) begin
      r  = ua - ub - cin;
      co = (ua >= ub + cin);
      sr = sa - sv - cin;
    end else begin
      r  = ua + ub + cin;
      co = (r >= m);
      sr = sa + sv + cin;
    end
    ov = (sr >= h) || (sr < -h);
    r  = ((r % m) + m) % m;
    return 32'(r) | (32'(co) << w) | (32'(ov) << (w + 1));
  endfunction

  function automatic logic [31:0] res16();
    return {14'd0, overflow, c_out, sum};
  endfunction

  task automatic start16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub, output int lat);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ia; b = ib; c_in = icin; sub = isub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic drain16(input string tag, input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                      input logic icin, input logic isub, input logic [31:0] exp, input int hold);
    int lat;
    start16(tag, ia, ib, icin, isub, lat);
    check({tag, "_result"}, res16(), exp);
    drain16(tag, hold);
  endtask

  task automatic op_small(input int k, input logic [3:0] ia, input logic [3:0] ib,
                          input logic icin, input logic isub);
    int    g     = 0;
    int    lat   = 0;
    int    steps = 4 >> k;
    string tag   = $sformatf("d%0d_%h_%h_c%0d_s%0d", 1 << k, ia, ib, icin, isub);
    while (!sm_in_ready[k] && g < 50) begin
      @(negedge clk);
      g++;
    end
    sm_in_valid[k] = 1'b1;
    sm_a[k] = ia; sm_b[k] = ib; sm_c_in[k] = icin; sm_sub[k] = isub;
    @(posedge clk);
    @(negedge clk);
    sm_in_valid[k] = 1'b0;
    sm_a[k] = 4'($urandom); sm_b[k] = 4'($urandom);
    while (!sm_out_valid[k] && lat < 50) begin
      sm_out_ready[k] = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    sm_out_ready[k] = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(steps));
    check({tag, "_res"}, {26'd0, sm_overflow[k], sm_c_out[k], sm_sum[k]},
          ref_model(4, int'(ia), int'(ib), icin, isub));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    sm_out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sm_out_ready[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sm_in_valid[k] = 1'b0; sm_out_ready[k] = 1'b0;
      sm_a[k] = '0; sm_b[k] = '0; sm_c_in[k] = 1'b0; sm_sub[k] = 1'b0;
    end
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    res16(),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op16("t1_add",     16'h1234, 16'h0FED, 1'b0, 1'b0, 32'h0_2221, 0);
    op16("t2_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h1_0000, 1);
    op16("t2_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 32'h2_8000, 0);
    op16("t3_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 32'h0_FFFE, 2);
    op16("t3_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 32'h3_7FFF, 0);
    op16("t3_borrow",  16'h0005, 16'h0002, 1'b1, 1'b1, 32'h1_0002, 0);

    // Backpressure: result must hold while new operands wait outside.
    start16("t4_first", 16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    in_valid = 1'b1;
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t4_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t4_hold_ready%0d", i), 32'(in_ready),  32'd0);
      check($sformatf("t4_hold_res%0d", i),   res16(),        32'h0_3333);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_after_drain_valid", 32'(out_valid), 32'd0);
    check("t4_after_drain_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("t4_second_latency", 32'(lat), 32'd4);
    check("t4_second_result",  res16(),  32'h0_FFFF);
    drain16("t4_second", 0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_in_ready",  32'(in_ready),  32'd1);
    check("t5_rst_result",    res16(),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_emit", 32'(out_valid), 32'd0);
    op16("t5_after", 16'h0001, 16'h0001, 1'b0, 1'b0, 32'h0_0002, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      op16($sformatf("rnd%0d", i), ra, rb, rc, rs,
           ref_model(16, int'(ra), int'(rb), rc, rs), int'($urandom_range(0, 3)));
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int v = 0; v < 1024; v++) begin
        op_small(k, 4'(v), 4'(v >> 4), 1'(v >> 8), 1'(v >> 9));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
